// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The ERR state exists only when PIPE_CTRL_TIMEOUT_EN is defined.
package pipeline_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

`ifdef PIPE_CTRL_TIMEOUT_EN
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1
  } state_e;
`endif

endpackage

// File: rtl/pipeline_ctrl_fwd_select.sv
// Priority comparator choosing the forwarding source for one ID-stage operand.
module fwd_select
  import pipeline_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             ex_wr,
  input  logic [REG_W-1:0] mem_dst,
  input  logic             mem_wr,
  input  logic [REG_W-1:0] wb_dst,
  input  logic             wb_wr,
  output logic [1:0]       sel
);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel = FWD_REG;
    if (src != '0) begin
      if (ex_wr && ex_dst == src)        sel = FWD_EX;
      else if (mem_wr && mem_dst == src) sel = FWD_MEM;
      else if (wb_wr && wb_dst == src)   sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard controller: forwarding, load-use stalls, branch flushes,
// memory-wait freeze and saturating event counters. Optional: PIPE_CTRL_TIMEOUT_EN.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      instr_top,
  input  logic [4:0]       ex_reg_dst,
  input  logic [4:0]       mem_reg_dst,
  input  logic [4:0]       wb_reg_dst,
  input  logic             ex_reg_write,
  input  logic             mem_reg_write,
  input  logic             wb_reg_write,
  input  logic             ex_mem_read,
  input  logic             mem_mem_read,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             if_we,
  output logic             id_we,
  output logic             ex_we,
  output logic             mem_we,
  output logic             if_flush,
  output logic             id_flush,
  output logic [1:0]       ctrl_rs,
  output logic [1:0]       ctrl_rt,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             bus_error
);

  logic [REG_W-1:0] rs, rt;
  assign rs = instr_top[9:5];
  assign rt = instr_top[4:0];

  fwd_select u_fwd_rs (
    .src(rs), .ex_dst(ex_reg_dst), .ex_wr(ex_reg_write),
    .mem_dst(mem_reg_dst), .mem_wr(mem_reg_write),
    .wb_dst(wb_reg_dst), .wb_wr(wb_reg_write), .sel(ctrl_rs)
  );

  fwd_select u_fwd_rt (
    .src(rt), .ex_dst(ex_reg_dst), .ex_wr(ex_reg_write),
    .mem_dst(mem_reg_dst), .mem_wr(mem_reg_write),
    .wb_dst(wb_reg_dst), .wb_wr(wb_reg_write), .sel(ctrl_rt)
  );

  logic lu;
  assign lu = (ex_mem_read && ex_reg_write && ex_reg_dst != '0 &&
               (ex_reg_dst == rs || ex_reg_dst == rt)) ||
              (mem_mem_read && mem_reg_write && mem_reg_dst != '0 &&
               (mem_reg_dst == rs || mem_reg_dst == rt));

  state_e state_q, state_d;
  logic   freeze;

`ifdef PIPE_CTRL_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wait_q;
`endif

  always_comb begin
    state_d = state_q;
    freeze  = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (mem_req && !mem_ready) begin
          state_d = ST_MEM_WAIT;
          freeze  = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        freeze = 1'b1;
        if (mem_ready) state_d = ST_RUN;
`ifdef PIPE_CTRL_TIMEOUT_EN
        else if (wait_q == WAIT_LAST) state_d = ST_ERR;
`endif
      end
`ifdef PIPE_CTRL_TIMEOUT_EN
      ST_ERR: freeze = 1'b1;
`endif
      default: state_d = ST_RUN;
    endcase

    pc_we    = 1'b1;
    if_we    = 1'b1;
    id_we    = 1'b1;
    ex_we    = 1'b1;
    mem_we   = 1'b1;
    if_flush = 1'b0;
    id_flush = 1'b0;
    // Freeze holds every stage, so lu and branch are simply re-evaluated after release.
    if (freeze) begin
      pc_we  = 1'b0;
      if_we  = 1'b0;
      id_we  = 1'b0;
      ex_we  = 1'b0;
      mem_we = 1'b0;
    end else if (branch_taken) begin
      if_flush = 1'b1;
      id_flush = 1'b1;
    end else if (lu) begin
      pc_we    = 1'b0;
      if_we    = 1'b0;
      id_flush = 1'b1;
    end
  end

  logic [CNT_W-1:0] stall_q, flush_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      if (!pc_we && stall_q != '1)   stall_q <= stall_q + 1'b1;
      if (if_flush && flush_q != '1) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;

`ifdef PIPE_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                               wait_q <= '0;
    else if (state_q == ST_MEM_WAIT && state_d == ST_MEM_WAIT) wait_q <= wait_q + 1'b1;
    else                                                     wait_q <= '0;
  end

  // ERR is left only by reset, so the sticky flag is the state itself.
  assign bus_error = (state_q == ST_ERR);
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
  assign bus_error      = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: combinational vector table plus multi-cycle sequences.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [15:0] instr_top;
  logic [4:0] ex_reg_dst, mem_reg_dst, wb_reg_dst;
  logic       ex_reg_write, mem_reg_write, wb_reg_write;
  logic       ex_mem_read, mem_mem_read, branch_taken, mem_req, mem_ready;
  logic       pc_we, if_we, id_we, ex_we, mem_we, if_flush, id_flush;
  logic [1:0] ctrl_rs, ctrl_rt;
  logic [3:0] stall_count, flush_count;
  logic       bus_error;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(4), .TIMEOUT(10)) dut (
    .clk(clk), .reset(reset), .instr_top(instr_top),
    .ex_reg_dst(ex_reg_dst), .mem_reg_dst(mem_reg_dst), .wb_reg_dst(wb_reg_dst),
    .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .ex_mem_read(ex_mem_read), .mem_mem_read(mem_mem_read),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_we(pc_we), .if_we(if_we), .id_we(id_we), .ex_we(ex_we), .mem_we(mem_we),
    .if_flush(if_flush), .id_flush(id_flush), .ctrl_rs(ctrl_rs), .ctrl_rt(ctrl_rt),
    .stall_count(stall_count), .flush_count(flush_count), .bus_error(bus_error)
  );

  typedef struct {
    logic [4:0] rs, rt, ex_dst, mem_dst, wb_dst;
    logic       ex_w, mem_w, wb_w, ex_mr, mem_mr, br;
    logic [1:0] e_rs, e_rt;
    logic [4:0] e_en;   // {pc, if, id, ex, mem}
    logic [1:0] e_fl;   // {if, id}
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] en_bits();
    return {pc_we, if_we, id_we, ex_we, mem_we};
  endfunction

  function automatic logic [1:0] fl_bits();
    return {if_flush, id_flush};
  endfunction

  task automatic idle();
    instr_top     = 16'h0000;
    ex_reg_dst    = 5'd0; mem_reg_dst = 5'd0; wb_reg_dst = 5'd0;
    ex_reg_write  = 1'b0; mem_reg_write = 1'b0; wb_reg_write = 1'b0;
    ex_mem_read   = 1'b0; mem_mem_read = 1'b0;
    branch_taken  = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt);
    instr_top = {6'h23, rs, rt};
  endtask

  initial begin
    vecs[0]  = '{5'd5, 5'd0, 5'd5, 5'd5, 5'd0, 1,1,0, 0,0,0, 2'd1, 2'd0, 5'b11111, 2'b00};
    vecs[1]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1,1,1, 0,0,0, 2'd0, 2'd0, 5'b11111, 2'b00};
    vecs[2]  = '{5'd5, 5'd7, 5'd3, 5'd5, 5'd7, 1,1,1, 0,0,0, 2'd2, 2'd3, 5'b11111, 2'b00};
    vecs[3]  = '{5'd9, 5'd2, 5'd9, 5'd0, 5'd9, 0,0,1, 0,0,0, 2'd3, 2'd0, 5'b11111, 2'b00};
    vecs[4]  = '{5'd1, 5'd3, 5'd3, 5'd0, 5'd0, 1,0,0, 1,0,0, 2'd0, 2'd1, 5'b00111, 2'b01};
    vecs[5]  = '{5'd4, 5'd0, 5'd0, 5'd4, 5'd0, 0,1,0, 0,1,0, 2'd2, 2'd0, 5'b00111, 2'b01};
    vecs[6]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1,0,0, 1,0,0, 2'd0, 2'd0, 5'b11111, 2'b00};
    vecs[7]  = '{5'd6, 5'd0, 5'd6, 5'd0, 5'd0, 0,0,0, 1,0,0, 2'd0, 2'd0, 5'b11111, 2'b00};
    vecs[8]  = '{5'd1, 5'd3, 5'd3, 5'd0, 5'd0, 1,0,0, 1,0,1, 2'd0, 2'd1, 5'b11111, 2'b11};
    vecs[9]  = '{5'd2, 5'd8, 5'd0, 5'd0, 5'd0, 0,0,0, 0,0,1, 2'd0, 2'd0, 5'b11111, 2'b11};
    vecs[10] = '{5'd0, 5'd12, 5'd0, 5'd12, 5'd12, 0,1,1, 0,0,0, 2'd0, 2'd2, 5'b11111, 2'b00};

    idle();
    reset = 1'b1;
    #1;
    check("rst_stall_count", 16'(stall_count), 16'd0);
    check("rst_flush_count", 16'(flush_count), 16'd0);
    check("rst_enables", 16'(en_bits()), 16'h1f);
    check("rst_flushes", 16'(fl_bits()), 16'd0);
    check("rst_bus_error", 16'(bus_error), 16'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      set_instr(vecs[i].rs, vecs[i].rt);
      ex_reg_dst    = vecs[i].ex_dst;
      mem_reg_dst   = vecs[i].mem_dst;
      wb_reg_dst    = vecs[i].wb_dst;
      ex_reg_write  = vecs[i].ex_w;
      mem_reg_write = vecs[i].mem_w;
      wb_reg_write  = vecs[i].wb_w;
      ex_mem_read   = vecs[i].ex_mr;
      mem_mem_read  = vecs[i].mem_mr;
      branch_taken  = vecs[i].br;
      #1;
      check($sformatf("vec%0d_ctrl_rs", i), 16'(ctrl_rs), 16'(vecs[i].e_rs));
      check($sformatf("vec%0d_ctrl_rt", i), 16'(ctrl_rt), 16'(vecs[i].e_rt));
      check($sformatf("vec%0d_enables", i), 16'(en_bits()), 16'(vecs[i].e_en));
      check($sformatf("vec%0d_flushes", i), 16'(fl_bits()), 16'(vecs[i].e_fl));
    end

    // Load-use: lw r3 directly ahead of a consumer of r3.
    do_reset();
    set_instr(5'd1, 5'd3);
    ex_reg_dst = 5'd3; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
    #1;
    check("lu_c1_pc_we", 16'(pc_we), 16'd0);
    check("lu_c1_id_flush", 16'(id_flush), 16'd1);
    @(negedge clk);
    ex_reg_dst = 5'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    mem_reg_dst = 5'd3; mem_reg_write = 1'b1; mem_mem_read = 1'b1;
    #1;
    check("lu_c2_pc_we", 16'(pc_we), 16'd0);
    check("lu_c2_id_flush", 16'(id_flush), 16'd1);
    @(negedge clk);
    mem_reg_dst = 5'd0; mem_reg_write = 1'b0; mem_mem_read = 1'b0;
    wb_reg_dst = 5'd3; wb_reg_write = 1'b1;
    #1;
    check("lu_c3_ctrl_rt", 16'(ctrl_rt), 16'd3);
    check("lu_c3_pc_we", 16'(pc_we), 16'd1);
    check("lu_stall_count", 16'(stall_count), 16'd2);

    // Branch overriding a load-use match.
    @(negedge clk);
    idle();
    set_instr(5'd1, 5'd3);
    ex_reg_dst = 5'd3; ex_reg_write = 1'b1; ex_mem_read = 1'b1; branch_taken = 1'b1;
    #1;
    check("br_lu_flushes", 16'(fl_bits()), 16'b11);
    check("br_lu_pc_we", 16'(pc_we), 16'd1);
    @(negedge clk);
    idle();
    #1;
    check("br_flush_count", 16'(flush_count), 16'd1);
    check("br_stall_count", 16'(stall_count), 16'd2);

    // Memory wait with branch_taken held: full freeze, flush only after release.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      mem_req = 1'b1; mem_ready = 1'b0; branch_taken = 1'b1;
      #1;
      check($sformatf("mw_c%0d_enables", c), 16'(en_bits()), 16'd0);
      check($sformatf("mw_c%0d_flushes", c), 16'(fl_bits()), 16'd0);
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check("mw_ready_enables", 16'(en_bits()), 16'd0);
    @(negedge clk);
    mem_req = 1'b0; mem_ready = 1'b0;
    #1;
    check("mw_after_enables", 16'(en_bits()), 16'h1f);
    check("mw_after_flushes", 16'(fl_bits()), 16'b11);
    @(negedge clk);
    idle();
    #1;
    check("mw_stall_count", 16'(stall_count), 16'd7);
    check("mw_flush_count", 16'(flush_count), 16'd2);

    // Back-to-back waits: re-entry right after the ready cycle.
    @(negedge clk);
    mem_req = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("b2b_run_pc_we", 16'(pc_we), 16'd0);
    @(negedge clk);
    mem_req = 1'b0;
    #1;
    check("b2b_wait_pc_we", 16'(pc_we), 16'd0);

    // Asynchronous reset while in MEM_WAIT.
    #1;
    reset = 1'b1;
    #1;
    check("rst_mw_enables", 16'(en_bits()), 16'h1f);
    check("rst_mw_stall_count", 16'(stall_count), 16'd0);
    check("rst_mw_flush_count", 16'(flush_count), 16'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("post_rst_pc_we", 16'(pc_we), 16'd1);

    // Stall counter saturation.
    @(negedge clk);
    set_instr(5'd3, 5'd0);
    ex_reg_dst = 5'd3; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
    repeat (20) @(negedge clk);
    idle();
    @(negedge clk);
    #1;
    check("sat_stall_count", 16'(stall_count), 16'd15);
    check("sat_flush_count", 16'(flush_count), 16'd0);

`ifdef PIPE_CTRL_TIMEOUT_EN
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("to_before_bus_error", 16'(bus_error), 16'd0);
    @(negedge clk);
    #1;
    check("to_bus_error", 16'(bus_error), 16'd1);
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    check("to_sticky_bus_error", 16'(bus_error), 16'd1);
    check("to_err_pc_we", 16'(pc_we), 16'd0);
    do_reset();
    #1;
    check("to_rst_bus_error", 16'(bus_error), 16'd0);
`else
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check("nto_bus_error", 16'(bus_error), 16'd0);
    check("nto_frozen_pc_we", 16'(pc_we), 16'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
